// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, defaults and grant encoding for the writeback arbiter
// Entry layout in the EX FIFO is {pc, data, rd, wen}; pc is present only with COMMIT_TRACE_EN.
package wb_arbiter_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_AW_DEF     = 5;
    localparam int EX_DEPTH_DEF   = 2;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [63:0] ZERO_64 = 64'h0;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_LSU  = 2'd1,
        GNT_FIFO = 2'd2
    } grant_e;

    // x0 is hardwired to zero, so a write to it is dropped like a store.
    function automatic logic wb_writes(input logic wen, input logic rd_nonzero);
        return wen & rd_nonzero;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - power-of-two FIFO buffering EX results ahead of the writeback port
// Pointers and count reset asynchronously; storage is not reset.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges EX and LSU results into one registered regfile write per cycle
// Optional COMMIT_TRACE_EN adds registered commit_valid/commit_pc for the difftest hook.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int EX_DEPTH   = EX_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_wen,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic [XLEN-1:0]   lsu_pc,
    output logic              rw_en,
    output logic [REG_AW-1:0] rw_addr,
    output logic [XLEN-1:0]   rw,
    output logic [63:0]       retire_cnt
`ifdef COMMIT_TRACE_EN
    ,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc
`endif
);

    localparam int CNT_W = $clog2(EX_DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
`ifdef COMMIT_TRACE_EN
    localparam int ENTRY_W = XLEN + XLEN + REG_AW + 1;
`else
    localparam int ENTRY_W = XLEN + REG_AW + 1;
`endif

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;

    logic [SW-1:0]      starve;
    logic [SW-1:0]      starve_nxt;
    grant_e             grant;
    logic               win_wen;
    logic [REG_AW-1:0]  win_rd;
    logic [XLEN-1:0]    win_data;
    logic               win_writes;

`ifdef COMMIT_TRACE_EN
    logic [XLEN-1:0]    win_pc;
    assign push_entry = {ex_pc, ex_data, ex_rd, ex_wen};
`else
    logic               unused_pc;
    assign push_entry = {ex_data, ex_rd, ex_wen};
    assign unused_pc  = ^{ex_pc, lsu_pc};
`endif

    assign ex_ready  = (fifo_count < CNT_W'(EX_DEPTH));
    assign lsu_ready = !((starve == SW'(STARVE_MAX)) && !fifo_empty);
    assign push      = ex_valid && ex_ready;
    assign pop       = (grant == GNT_FIFO);

    wb_fifo #(
        .DEPTH (EX_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // LSU has no buffer, so it wins unless it has already starved a waiting EX result.
    always_comb begin
        grant    = GNT_IDLE;
        win_wen  = 1'b0;
        win_rd   = '0;
        win_data = '0;
`ifdef COMMIT_TRACE_EN
        win_pc   = '0;
`endif
        if (lsu_valid && lsu_ready) begin
            grant    = GNT_LSU;
            win_wen  = lsu_wen;
            win_rd   = lsu_rd;
            win_data = lsu_data;
`ifdef COMMIT_TRACE_EN
            win_pc   = lsu_pc;
`endif
        end else if (!fifo_empty) begin
            grant    = GNT_FIFO;
            win_wen  = head[0];
            win_rd   = head[REG_AW:1];
            win_data = head[REG_AW+XLEN:REG_AW+1];
`ifdef COMMIT_TRACE_EN
            win_pc   = head[ENTRY_W-1 -: XLEN];
`endif
        end
    end

    assign win_writes = wb_writes(win_wen, win_rd != '0);

    always_comb begin
        starve_nxt = starve;
        if (fifo_empty || grant == GNT_FIFO) begin
            starve_nxt = '0;
        end else if (grant == GNT_LSU && starve != SW'(STARVE_MAX)) begin
            starve_nxt = starve + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve     <= '0;
            rw_en      <= 1'b0;
            rw_addr    <= '0;
            rw         <= '0;
            retire_cnt <= ZERO_64;
        end else begin
            starve <= starve_nxt;
            rw_en  <= 1'b0;
            if (grant != GNT_IDLE) begin
                retire_cnt <= retire_cnt + 64'd1;
                rw_en      <= win_writes;
                rw_addr    <= win_writes ? win_rd : '0;
                rw         <= win_writes ? win_data : '0;
            end
        end
    end

`ifdef COMMIT_TRACE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            commit_valid <= (grant != GNT_IDLE);
            if (grant != GNT_IDLE) begin
                commit_pc <= win_pc;
            end
        end
    end
`endif

endmodule
